contador_bcd_multidigito: RTL and testbench

CONTADOR_BCD_MULTIDIGITO -- requirements
Module: contador_bcd_multidigito

---
 rtl/contador_bcd_multidigito.sv | 158 +++++++++++++++
 tb/tb_contador_bcd_multidigito.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/contador_bcd_multidigito.sv
// rtl/contador_bcd_multidigito.sv - cascaded BCD up/down counter with count/lap/stop/clear control
module contador_bcd_multidigito #(
    parameter int DIGITS  = 2,
    parameter int MOD_MSD = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  contar,
    input  logic                  pausar,
    input  logic                  parar,
    input  logic                  zerar,
    input  logic                  descer,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_valor,
    output logic [4*DIGITS-1:0]   num_saida_contador,
    output logic [4*DIGITS-1:0]   num_saida_display,
    output logic                  carry_out,
    output logic [1:0]            estado
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_CONTAR = 2'd1,
        ST_PAUSAR = 2'd2,
        ST_PARAR  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [W-1:0]   r_count;
    logic [W-1:0]   r_display;
    logic           r_carry;
    logic [W-1:0]   w_count_step;
    logic [W-1:0]   w_load_sat;
    logic           w_count_en;
    logic           w_load_en;
    logic           w_wrap;
    logic           w_chain;
    logic [3:0]     w_digit;
    logic [3:0]     w_max;
    logic [3:0]     w_ld_digit;
    logic [3:0]     w_ld_max;

    // Largest legal value of digit k: the top digit uses MOD_MSD, the rest are decimal.
    function automatic logic [3:0] digit_max(input int k);
        return (k == DIGITS - 1) ? 4'(MOD_MSD - 1) : 4'd9;
    endfunction

    // Counting happens in CONTAR and in PAUSAR (lap mode keeps time running).
    assign w_count_en = tick && ((r_state == ST_CONTAR) || (r_state == ST_PAUSAR));
    // Presets are only taken while the counter is idle or stopped.
    assign w_load_en  = load && ((r_state == ST_RESET) || (r_state == ST_PARAR));

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; clear beats everything, and an accepted load freezes the state.
    always_comb begin
        w_next_state = r_state;
        if (zerar) begin
            w_next_state = ST_RESET;
        end else if (w_load_en) begin
            w_next_state = r_state;
        end else begin
            case (r_state)
                ST_RESET: begin
                    if (pausar)      w_next_state = ST_PAUSAR;
                    else if (contar) w_next_state = ST_CONTAR;
                end
                ST_CONTAR: begin
                    if (parar)       w_next_state = ST_PARAR;
                    else if (pausar) w_next_state = ST_PAUSAR;
                end
                ST_PAUSAR: begin
                    if (contar)      w_next_state = ST_CONTAR;
                    else if (parar)  w_next_state = ST_PARAR;
                end
                ST_PARAR: begin
                    if (contar)      w_next_state = ST_CONTAR;
                end
                default: w_next_state = ST_RESET;
            endcase
        end
    end

    // Ripple the up/down step through the digits; w_chain stays high while every lower digit sits at its boundary.
    always_comb begin
        w_count_step = r_count;
        w_chain      = 1'b1;
        w_digit      = 4'd0;
        w_max        = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            w_digit = r_count[4*k +: 4];
            w_max   = digit_max(k);
            if (w_chain) begin
                if (descer) begin
                    w_count_step[4*k +: 4] = (w_digit == 4'd0) ? w_max : (w_digit - 4'd1);
                end else begin
                    w_count_step[4*k +: 4] = (w_digit >= w_max) ? 4'd0 : (w_digit + 4'd1);
                end
            end
            w_chain = w_chain && (descer ? (w_digit == 4'd0) : (w_digit >= w_max));
        end
        w_wrap = w_chain;
    end

    // Clamp each preset digit to its maximum so the counter never holds an illegal code.
    always_comb begin
        w_load_sat = '0;
        w_ld_digit = 4'd0;
        w_ld_max   = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            w_ld_digit = load_valor[4*k +: 4];
            w_ld_max   = digit_max(k);
            w_load_sat[4*k +: 4] = (w_ld_digit > w_ld_max) ? w_ld_max : w_ld_digit;
        end
    end

    // Count, display and wrap pulse; the display is frozen only while sitting in PAUSAR.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count   <= '0;
            r_display <= '0;
            r_carry   <= 1'b0;
        end else if (zerar) begin
            r_count   <= '0;
            r_display <= '0;
            r_carry   <= 1'b0;
        end else if (w_load_en) begin
            r_count   <= w_load_sat;
            r_display <= w_load_sat;
            r_carry   <= 1'b0;
        end else begin
            r_carry <= w_count_en && w_wrap;
            if (w_count_en) begin
                r_count <= w_count_step;
            end
            if (r_state != ST_PAUSAR) begin
                r_display <= w_count_en ? w_count_step : r_count;
            end
        end
    end

    assign num_saida_contador = r_count;
    assign num_saida_display  = r_display;
    assign carry_out          = r_carry;
    assign estado             = r_state;

endmodule

// File: tb/tb_contador_bcd_multidigito.sv
// tb/tb_contador_bcd_multidigito.sv - self-checking bench for contador_bcd_multidigito
module tb_contador_bcd_multidigito;

    localparam int DIGITS  = 2;
    localparam int MOD_MSD = 6;
    localparam int W       = 4 * DIGITS;
    localparam int TOTAL   = MOD_MSD * (10 ** (DIGITS - 1));

    logic          clock = 1'b0;
    logic          reset;
    logic          tick, contar, pausar, parar, zerar, descer, load;
    logic [W-1:0]  load_valor;
    logic [W-1:0]  num_saida_contador, num_saida_display;
    logic          carry_out;
    logic [1:0]    estado;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: count kept as a plain integer modulo TOTAL.
    int m_state = 0;
    int m_val   = 0;
    int m_disp  = 0;
    bit m_carry = 1'b0;

    contador_bcd_multidigito #(.DIGITS(DIGITS), .MOD_MSD(MOD_MSD)) dut (
        .clock              (clock),
        .reset              (reset),
        .tick               (tick),
        .contar             (contar),
        .pausar             (pausar),
        .parar              (parar),
        .zerar              (zerar),
        .descer             (descer),
        .load               (load),
        .load_valor         (load_valor),
        .num_saida_contador (num_saida_contador),
        .num_saida_display  (num_saida_display),
        .carry_out          (carry_out),
        .estado             (estado)
    );

    always #5 clock = ~clock;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int p;
        r = '0;
        p = v;
        for (int k = 0; k < DIGITS; k++) begin
            if (k == DIGITS - 1) r[4*k +: 4] = 4'(p);
            else                 r[4*k +: 4] = 4'(p % 10);
            p = p / 10;
        end
        return r;
    endfunction

    function automatic int sat_val(input logic [W-1:0] lv);
        int v, wgt, d, mx;
        v = 0;
        wgt = 1;
        for (int k = 0; k < DIGITS; k++) begin
            d  = int'(lv[4*k +: 4]);
            mx = (k == DIGITS - 1) ? MOD_MSD - 1 : 9;
            if (d > mx) d = mx;
            v   += d * wgt;
            wgt *= 10;
        end
        return v;
    endfunction

    function automatic logic [2+1+2*W-1:0] expected();
        return {2'(m_state), m_carry, to_bcd(m_disp), to_bcd(m_val)};
    endfunction

    task automatic apply(input bit t, input bit c, input bit p, input bit s,
                         input bit z, input bit d, input bit l, input logic [W-1:0] lv);
        int  nv;
        bit  en;
        tick = t; contar = c; pausar = p; parar = s;
        zerar = z; descer = d; load = l; load_valor = lv;
        @(posedge clock);
        if (z) begin
            m_state = 0; m_val = 0; m_disp = 0; m_carry = 0;
        end else if (l && (m_state == 0 || m_state == 3)) begin
            m_val = sat_val(lv); m_disp = m_val; m_carry = 0;
        end else begin
            en = t && (m_state == 1 || m_state == 2);
            nv = m_val;
            if (en) nv = d ? (m_val + TOTAL - 1) % TOTAL : (m_val + 1) % TOTAL;
            m_carry = en && (d ? (m_val == 0) : (m_val == TOTAL - 1));
            if (m_state != 2) m_disp = nv;
            m_val = nv;
            case (m_state)
                0: m_state = p ? 2 : (c ? 1 : 0);
                1: m_state = s ? 3 : (p ? 2 : 1);
                2: m_state = c ? 1 : (s ? 3 : 2);
                default: m_state = c ? 1 : 3;
            endcase
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick = 0; contar = 0; pausar = 0; parar = 0; zerar = 0; descer = 0; load = 0;
        load_valor = '0;
        #2;
        n_checks++;
        if ({estado, carry_out, num_saida_display, num_saida_contador} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_state: got st=%0d c=%0b d=%h n=%h, expected all zero",
                     estado, carry_out, num_saida_display, num_saida_contador);
        end
        @(negedge clock);
        reset = 1'b1;
        m_state = 0; m_val = 0; m_disp = 0; m_carry = 0;
        apply(0, 0, 0, 0, 0, 0, 0, '0);
        n_checks++;
        if ({estado, carry_out, num_saida_display, num_saida_contador} !== expected()) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected %h",
                     {estado, carry_out, num_saida_display, num_saida_contador}, expected());
        end
    endtask

    task automatic test_full_wrap();
        apply(0, 0, 0, 0, 1, 0, 0, '0);
        apply(0, 1, 0, 0, 0, 0, 0, '0);
        for (int i = 1; i <= TOTAL; i++) begin
            apply(1, 0, 0, 0, 0, 0, 0, '0);
            n_checks++;
            if ({estado, carry_out, num_saida_display, num_saida_contador} !== expected()) begin
                n_fail++;
                $display("FAIL up_tick_%0d: got %h expected %h", i,
                         {estado, carry_out, num_saida_display, num_saida_contador}, expected());
            end
            if (i == TOTAL - 1) begin
                n_checks++;
                if (num_saida_contador !== 8'h59 || carry_out !== 1'b0) begin
                    n_fail++;
                    $display("FAIL up_59: got n=%h c=%0b expected n=59 c=0", num_saida_contador, carry_out);
                end
            end
            if (i == TOTAL) begin
                n_checks++;
                if (num_saida_contador !== 8'h00 || carry_out !== 1'b1) begin
                    n_fail++;
                    $display("FAIL up_wrap: got n=%h c=%0b expected n=00 c=1", num_saida_contador, carry_out);
                end
            end
        end
        apply(0, 0, 0, 0, 0, 0, 0, '0);
        n_checks++;
        if (carry_out !== 1'b0 || num_saida_display !== 8'h00) begin
            n_fail++;
            $display("FAIL carry_one_cycle: got c=%0b d=%h expected c=0 d=00", carry_out, num_saida_display);
        end
    endtask

    task automatic test_down_wrap();
        apply(0, 0, 0, 0, 1, 0, 0, '0);
        apply(0, 1, 0, 0, 0, 0, 0, '0);
        apply(1, 0, 0, 0, 0, 1, 0, '0);
        n_checks++;
        if (num_saida_contador !== 8'h59 || carry_out !== 1'b1) begin
            n_fail++;
            $display("FAIL down_wrap: got n=%h c=%0b expected n=59 c=1", num_saida_contador, carry_out);
        end
        apply(1, 0, 0, 0, 0, 1, 0, '0);
        n_checks++;
        if (num_saida_contador !== 8'h58 || carry_out !== 1'b0) begin
            n_fail++;
            $display("FAIL down_next: got n=%h c=%0b expected n=58 c=0", num_saida_contador, carry_out);
        end
    endtask

    task automatic test_pause();
        apply(0, 0, 0, 0, 1, 0, 0, '0);
        apply(0, 0, 0, 0, 0, 0, 1, 8'h12);
        apply(0, 1, 0, 0, 0, 0, 0, '0);
        apply(0, 0, 1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 5; i++) apply(1, 0, 0, 0, 0, 0, 0, '0);
        n_checks++;
        if (num_saida_contador !== 8'h17 || num_saida_display !== 8'h12 || estado !== 2'd2) begin
            n_fail++;
            $display("FAIL lap_hold: got n=%h d=%h st=%0d expected n=17 d=12 st=2",
                     num_saida_contador, num_saida_display, estado);
        end
        apply(0, 1, 0, 0, 0, 0, 0, '0);
        apply(0, 0, 0, 0, 0, 0, 0, '0);
        n_checks++;
        if (num_saida_display !== 8'h17 || estado !== 2'd1) begin
            n_fail++;
            $display("FAIL lap_resume: got d=%h st=%0d expected d=17 st=1", num_saida_display, estado);
        end
    endtask

    task automatic test_load();
        apply(0, 0, 0, 0, 1, 0, 0, '0);
        apply(0, 1, 0, 0, 0, 0, 0, '0);
        apply(0, 0, 0, 1, 0, 0, 0, '0);
        apply(0, 0, 0, 0, 0, 0, 1, 8'h7A);
        n_checks++;
        if (num_saida_contador !== 8'h59 || num_saida_display !== 8'h59 || estado !== 2'd3) begin
            n_fail++;
            $display("FAIL load_sat: got n=%h d=%h st=%0d expected n=59 d=59 st=3",
                     num_saida_contador, num_saida_display, estado);
        end
        apply(1, 0, 0, 0, 0, 0, 1, 8'h05);
        n_checks++;
        if (num_saida_contador !== 8'h05 || estado !== 2'd3) begin
            n_fail++;
            $display("FAIL load_beats_tick: got n=%h st=%0d expected n=05 st=3", num_saida_contador, estado);
        end
        apply(0, 1, 0, 0, 0, 0, 0, '0);
        apply(0, 0, 0, 0, 0, 0, 1, 8'h23);
        n_checks++;
        if (num_saida_contador !== 8'h05 || estado !== 2'd1) begin
            n_fail++;
            $display("FAIL load_ignored: got n=%h st=%0d expected n=05 st=1", num_saida_contador, estado);
        end
    endtask

    task automatic test_coincident();
        apply(0, 0, 0, 0, 1, 0, 0, '0);
        apply(1, 1, 0, 0, 0, 0, 0, '0);
        n_checks++;
        if (num_saida_contador !== 8'h00 || estado !== 2'd1) begin
            n_fail++;
            $display("FAIL tick_on_entry: got n=%h st=%0d expected n=00 st=1", num_saida_contador, estado);
        end
        apply(1, 0, 0, 1, 0, 0, 0, '0);
        n_checks++;
        if (num_saida_contador !== 8'h01 || num_saida_display !== 8'h01 || estado !== 2'd3) begin
            n_fail++;
            $display("FAIL tick_on_exit: got n=%h d=%h st=%0d expected n=01 d=01 st=3",
                     num_saida_contador, num_saida_display, estado);
        end
    endtask

    task automatic test_async_reset();
        apply(0, 0, 0, 0, 1, 0, 0, '0);
        apply(0, 0, 0, 0, 0, 0, 1, 8'h34);
        apply(0, 1, 0, 0, 0, 0, 0, '0);
        n_checks++;
        if (num_saida_contador !== 8'h34 || estado !== 2'd1) begin
            n_fail++;
            $display("FAIL pre_reset: got n=%h st=%0d expected n=34 st=1", num_saida_contador, estado);
        end
        tick = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({estado, carry_out, num_saida_display, num_saida_contador} !== 19'd0) begin
            n_fail++;
            $display("FAIL async_reset: got st=%0d c=%0b d=%h n=%h expected all zero",
                     estado, carry_out, num_saida_display, num_saida_contador);
        end
        m_state = 0; m_val = 0; m_disp = 0; m_carry = 0;
        @(negedge clock);
        reset = 1'b1;
        apply(1, 1, 0, 0, 0, 0, 0, '0);
        apply(1, 1, 0, 0, 1, 0, 0, '0);
        n_checks++;
        if (num_saida_contador !== 8'h00 || estado !== 2'd0 || carry_out !== 1'b0) begin
            n_fail++;
            $display("FAIL zerar_tick: got n=%h st=%0d c=%0b expected n=00 st=0 c=0",
                     num_saida_contador, estado, carry_out);
        end
    endtask

    task automatic test_random();
        bit d;
        d = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) d = ~d;
            apply(bit'($urandom_range(1)),
                  $urandom_range(5) == 0,
                  $urandom_range(7) == 0,
                  $urandom_range(7) == 0,
                  $urandom_range(39) == 0,
                  d,
                  $urandom_range(7) == 0,
                  W'($urandom));
            n_checks++;
            if ({estado, carry_out, num_saida_display, num_saida_contador} !== expected()) begin
                n_fail++;
                $display("FAIL random_%0d: got st=%0d c=%0b d=%h n=%h expected %h", i,
                         estado, carry_out, num_saida_display, num_saida_contador, expected());
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_wrap();
        test_down_wrap();
        test_pause();
        test_load();
        test_coincident();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
